// File: rtl/gene_loader.sv
// rtl/gene_loader.sv - packs a 2-bit base stream into nibbles and writes them to gene memory
module gene_loader #(
  parameter int          ADDR_W   = 8,
  parameter logic [1:0]  PAD_BASE = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              base_valid,
  input  logic [1:0]        base,
  input  logic              seq_end,
  output logic              base_ready,
  output logic [ADDR_W-1:0] addr_gen,
  output logic [3:0]        din_gen,
  output logic              we_gen,
  output logic [ADDR_W:0]   nib_cnt,
  output logic              done_load,
  output logic              full
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] MAX_CNT = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_q, state_d;
  logic [3:0]          nib_q, nib_d;
  logic [3:0]          din_q, din_d;
  logic                seq_q, seq_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [ADDR_W:0]     cnt_inc;
  logic                full_q, full_d;
  logic                accept;

  assign base_ready = (state_q == S_HI) || (state_q == S_LO);
  assign accept     = base_valid && base_ready;
  assign cnt_inc    = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      nib_q   <= '0;
      din_q   <= '0;
      seq_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      din_q   <= din_d;
      seq_q   <= seq_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
    end
  end

  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    din_d   = din_q;
    seq_d   = seq_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_HI;
          addr_d  = '0;
          cnt_d   = '0;
          full_d  = 1'b0;
          seq_d   = 1'b0;
        end
      end
      S_HI: begin
        if (seq_end) seq_d = 1'b1;
        if (accept) begin
          if (seq_end) begin
            nib_d   = {base, PAD_BASE};
            din_d   = {base, PAD_BASE};
            state_d = S_WR;
          end else begin
            nib_d   = {base, nib_q[1:0]};
            state_d = S_LO;
          end
        end else if (seq_end) begin
          state_d = S_DONE;
        end
      end
      S_LO: begin
        if (seq_end) seq_d = 1'b1;
        if (accept) begin
          nib_d   = {nib_q[3:2], base};
          din_d   = {nib_q[3:2], base};
          state_d = S_WR;
        end else if (seq_end) begin
          nib_d   = {nib_q[3:2], PAD_BASE};
          din_d   = {nib_q[3:2], PAD_BASE};
          state_d = S_WR;
        end
      end
      S_WR: begin
        cnt_d = cnt_inc;
        // The address saturates on the final slot so it never wraps back to 0 mid-load.
        if (addr_q != '1) addr_d = addr_q + 1'b1;
        if (cnt_inc == MAX_CNT) begin
          full_d  = 1'b1;
          state_d = S_DONE;
        end else if (seq_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_HI;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign we_gen    = (state_q == S_WR);
  assign done_load = (state_q == S_DONE);
  assign din_gen   = din_q;
  assign addr_gen  = addr_q;
  assign nib_cnt   = cnt_q;
  assign full      = full_q;

endmodule

// File: tb/tb_gene_loader.sv
// tb/tb_gene_loader.sv - directed self-checking bench for gene_loader
module tb_gene_loader;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              base_valid = 1'b0;
  logic [1:0]        base = 2'b00;
  logic              seq_end = 1'b0;
  logic              base_ready;
  logic [ADDR_W-1:0] addr_gen;
  logic [3:0]        din_gen;
  logic              we_gen;
  logic [ADDR_W:0]   nib_cnt;
  logic              done_load;
  logic              full;

  int errors = 0;
  int checks = 0;

  logic [ADDR_W-1:0] wa[$];
  logic [3:0]        wd[$];
  logic [1:0]        bs[512];

  gene_loader #(.ADDR_W(ADDR_W), .PAD_BASE(2'b00)) dut (
    .clk(clk), .rst(rst), .start(start), .base_valid(base_valid), .base(base),
    .seq_end(seq_end), .base_ready(base_ready), .addr_gen(addr_gen), .din_gen(din_gen),
    .we_gen(we_gen), .nib_cnt(nib_cnt), .done_load(done_load), .full(full)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we_gen) begin
      wa.push_back(addr_gen);
      wd.push_back(din_gen);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] b, input logic se);
    int n = 0;
    base = b;
    base_valid = 1'b1;
    seq_end = se;
    while (!base_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("ready_timeout", base_ready, 1);
    tick();
    base_valid = 1'b0;
    seq_end = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done_load && n < 10) begin
      tick();
      n++;
    end
    check(tag, done_load, 1);
  endtask

  task automatic check_wr(input string tag, input int idx, input logic [ADDR_W-1:0] a,
                          input logic [3:0] d);
    if (idx < wa.size()) begin
      check({tag, "_addr"}, wa[idx], a);
      check({tag, "_data"}, wd[idx], d);
    end else begin
      check({tag, "_missing"}, wa.size(), idx + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mism;

    // Reset values while rst is held
    tick();
    tick();
    check("rst_ready", base_ready, 0);
    check("rst_we", we_gen, 0);
    check("rst_done", done_load, 0);
    check("rst_full", full, 0);
    check("rst_addr", addr_gen, 0);
    check("rst_din", din_gen, 0);
    check("rst_cnt", nib_cnt, 0);
    rst = 1'b0;
    tick();
    tick();
    tick();
    check("idle_ready", base_ready, 0);
    check("idle_done", done_load, 0);
    check("idle_we", we_gen, 0);

    // C,G,T,A back-to-back, seq_end with A
    wa.delete(); wd.delete();
    pulse_start();
    send(2'b01, 1'b0);
    send(2'b10, 1'b0);
    send(2'b11, 1'b0);
    send(2'b00, 1'b1);
    wait_done("t1_done");
    check("t1_nwr", wa.size(), 2);
    check_wr("t1_w0", 0, 8'd0, 4'b0110);
    check_wr("t1_w1", 1, 8'd1, 4'b1100);
    check("t1_cnt", nib_cnt, 2);
    check("t1_full", full, 0);
    check("t1_addr", addr_gen, 2);
    check("t1_din_hold", din_gen, 4'b1100);

    // G,T,C with seq_end on C, C padded
    wa.delete(); wd.delete();
    pulse_start();
    check("t2_addr_clr", addr_gen, 0);
    check("t2_done_clr", done_load, 0);
    send(2'b10, 1'b0);
    send(2'b11, 1'b0);
    send(2'b01, 1'b1);
    wait_done("t2_done");
    check("t2_nwr", wa.size(), 2);
    check_wr("t2_w0", 0, 8'd0, 4'b1011);
    check_wr("t2_w1", 1, 8'd1, 4'b0100);
    check("t2_cnt", nib_cnt, 2);

    // seq_end in HI with no base
    wa.delete(); wd.delete();
    pulse_start();
    seq_end = 1'b1;
    tick();
    seq_end = 1'b0;
    check("t3_done", done_load, 1);
    check("t3_cnt", nib_cnt, 0);
    base_valid = 1'b1;
    seq_end = 1'b1;
    tick();
    tick();
    check("t3_ready", base_ready, 0);
    check("t3_done_hold", done_load, 1);
    base_valid = 1'b0;
    seq_end = 1'b0;
    check("t3_nwr", wa.size(), 0);

    // 512 bases, no seq_end: memory fills
    wa.delete(); wd.delete();
    for (int i = 0; i < 512; i++) bs[i] = 2'(i ^ (i >> 3));
    pulse_start();
    for (int i = 0; i < 512; i++) send(bs[i], 1'b0);
    wait_done("t4_done");
    check("t4_nwr", wa.size(), 256);
    mism = 0;
    for (int k = 0; k < 256 && k < wa.size(); k++) begin
      if (wa[k] !== 8'(k)) mism++;
      if (wd[k] !== {bs[2*k], bs[2*k+1]}) mism++;
    end
    check("t4_mism", mism, 0);
    check("t4_full", full, 1);
    check("t4_cnt", nib_cnt, 256);
    check("t4_addr", addr_gen, 255);
    base_valid = 1'b1;
    tick();
    check("t4_ready", base_ready, 0);
    base_valid = 1'b0;

    // rst during WR of the fourth nibble
    wa.delete(); wd.delete();
    pulse_start();
    for (int i = 0; i < 8; i++) send(2'(i + 1), 1'b0);
    check("t5_we_before", we_gen, 1);
    rst = 1'b1;
    #1;
    check("t5_we", we_gen, 0);
    check("t5_addr", addr_gen, 0);
    check("t5_din", din_gen, 0);
    check("t5_cnt", nib_cnt, 0);
    check("t5_ready", base_ready, 0);
    check("t5_done", done_load, 0);
    check("t5_full", full, 0);
    tick();
    check("t5_nwr", wa.size(), 3);
    tick();
    rst = 1'b0;
    tick();
    check("t5_idle", base_ready, 0);
    wa.delete(); wd.delete();
    pulse_start();
    send(2'b11, 1'b0);
    send(2'b01, 1'b1);
    wait_done("t5_done2");
    check("t5_nwr2", wa.size(), 1);
    check_wr("t5_w0", 0, 8'd0, 4'b1101);

    // start pulsed during LO is ignored
    wa.delete(); wd.delete();
    pulse_start();
    send(2'b10, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_ready_lo", base_ready, 1);
    check("t6_addr", addr_gen, 0);
    send(2'b11, 1'b0);
    send(2'b00, 1'b1);
    wait_done("t6_done");
    check("t6_nwr", wa.size(), 2);
    check_wr("t6_w0", 0, 8'd0, 4'b1011);
    check_wr("t6_w1", 1, 8'd1, 4'b0000);
    check("t6_cnt", nib_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
